// File: rtl/sprite_renderer.sv
// rtl/sprite_renderer.sv - sprite overlay stage between VGA scan and sprite ROM
// Two-cycle pixel pipeline: box test and ROM address, then colour-key composite.
module sprite_renderer #(
  parameter int          COORD_W     = 10,
  parameter int          SCALE_SHIFT = 0,
  parameter logic [23:0] KEY_COLOR   = 24'h000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic               active_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic [23:0]        bg_rgb,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] sprite_x,
  input  logic [COORD_W-1:0] sprite_y,
  input  logic               sprite_en,
  output logic [7:0]         rom_addr,
  input  logic [23:0]        rom_data,
  output logic [23:0]        rgb_out,
  output logic               active_out,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               sprite_hit
);

  localparam logic [COORD_W:0] BOX_SIZE = (COORD_W+1)'(16 << SCALE_SHIFT);

  logic [COORD_W-1:0] pos_x_q, pos_x_d;
  logic [COORD_W-1:0] pos_y_q, pos_y_d;
  logic               en_q, en_d;
  logic [7:0]         rom_addr_q, rom_addr_d;
  logic               in_box_d1_q, in_box_d1_d;
  logic               active_d1_q, active_d1_d;
  logic [23:0]        bg_d1_q, bg_d1_d;
  logic               hsync_d1_q, hsync_d1_d;
  logic               vsync_d1_q, vsync_d1_d;
  logic [23:0]        rgb_q, rgb_d;
  logic               active_out_q, active_out_d;
  logic               hsync_out_q, hsync_out_d;
  logic               vsync_out_q, vsync_out_d;
  logic               hit_q, hit_d;

  logic [COORD_W:0]   dx, dy;
  logic               in_box;
  logic               draw;

  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    en_d    = en_q;
    if (frame_start) begin
      pos_x_d = sprite_x;
      pos_y_d = sprite_y;
      en_d    = sprite_en;
    end

    // Extra MSB of the subtraction flags beam left of / above the sprite, so no wrap.
    dx = {1'b0, pixel_x} - {1'b0, pos_x_q};
    dy = {1'b0, pixel_y} - {1'b0, pos_y_q};
    in_box = en_q && active_in && !dx[COORD_W] && !dy[COORD_W]
             && (dx < BOX_SIZE) && (dy < BOX_SIZE);

    rom_addr_d  = in_box ? {dy[SCALE_SHIFT+3:SCALE_SHIFT], dx[SCALE_SHIFT+3:SCALE_SHIFT]} : 8'h00;
    in_box_d1_d = in_box;
    active_d1_d = active_in;
    bg_d1_d     = bg_rgb;
    hsync_d1_d  = hsync_in;
    vsync_d1_d  = vsync_in;

    draw = in_box_d1_q && (rom_data != KEY_COLOR);
    if (!active_d1_q)  rgb_d = 24'h000000;
    else if (draw)     rgb_d = rom_data;
    else               rgb_d = bg_d1_q;
    active_out_d = active_d1_q;
    hsync_out_d  = hsync_d1_q;
    vsync_out_d  = vsync_d1_q;

    // Frame boundary clear takes priority over a coincident draw.
    hit_d = hit_q | draw;
    if (frame_start) hit_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_x_q      <= '0;
      pos_y_q      <= '0;
      en_q         <= 1'b0;
      rom_addr_q   <= 8'h00;
      in_box_d1_q  <= 1'b0;
      active_d1_q  <= 1'b0;
      bg_d1_q      <= 24'h000000;
      hsync_d1_q   <= 1'b1;
      vsync_d1_q   <= 1'b1;
      rgb_q        <= 24'h000000;
      active_out_q <= 1'b0;
      hsync_out_q  <= 1'b1;
      vsync_out_q  <= 1'b1;
      hit_q        <= 1'b0;
    end else begin
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      en_q         <= en_d;
      rom_addr_q   <= rom_addr_d;
      in_box_d1_q  <= in_box_d1_d;
      active_d1_q  <= active_d1_d;
      bg_d1_q      <= bg_d1_d;
      hsync_d1_q   <= hsync_d1_d;
      vsync_d1_q   <= vsync_d1_d;
      rgb_q        <= rgb_d;
      active_out_q <= active_out_d;
      hsync_out_q  <= hsync_out_d;
      vsync_out_q  <= vsync_out_d;
      hit_q        <= hit_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign rgb_out    = rgb_q;
  assign active_out = active_out_q;
  assign hsync_out  = hsync_out_q;
  assign vsync_out  = vsync_out_q;
  assign sprite_hit = hit_q;

endmodule
